// File: rtl/muladd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muladd_pkg
// Description : Opcodes, latency and width helper shared by the muladd_acc unit.
// Revision    : 1.0
// ============================================================================
package muladd_pkg;

    localparam logic [1:0] OP_MACC = 2'b00;
    localparam logic [1:0] OP_MSUB = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_MNEG = 2'b11;

    localparam int OUT_LATENCY = 4;

    function automatic int acc_width(input int data_w, input int guard_w);
        return 2 * data_w + guard_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muladd_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muladd_acc_ctrl
// Description : Start delay, period/iteration counters, done flag and first.
// Revision    : 1.0
// ============================================================================
module muladd_acc_ctrl
    import muladd_pkg::*;
#(
    parameter int ITER_W  = 10,
    parameter int DELAY_W = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_i,
    input  logic [ITER_W-1:0]  iter_i,
    input  logic [ITER_W-1:0]  period_i,
    input  logic [DELAY_W-1:0] delay0_i,
    output logic               done_o,
    output logic               first_o
);

    logic [DELAY_W:0]  delay_q, delay_d;
    logic [ITER_W-1:0] per_q, per_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              done_q, done_d;
    logic [ITER_W:0]   w_per_inc;
    logic [ITER_W:0]   w_iter_inc;

    assign w_per_inc  = {1'b0, per_q} + 1'b1;
    assign w_iter_inc = {1'b0, iter_q} + 1'b1;

    always_comb begin
        delay_d = delay_q;
        per_d   = per_q;
        iter_d  = iter_q;
        done_d  = done_q;
        if (run_i) begin
            // The extra 2 cycles line the first product up with S3.
            delay_d = {1'b0, delay0_i} + 2'd2;
            per_d   = '0;
            iter_d  = '0;
            done_d  = 1'b0;
        end else if (delay_q != '0) begin
            delay_d = delay_q - 1'b1;
            per_d   = '0;
            iter_d  = '0;
            if (iter_i == '0) begin
                done_d = 1'b1;
            end
        end else if (!done_q) begin
            if (w_per_inc >= {1'b0, period_i}) begin
                per_d  = '0;
                iter_d = w_iter_inc[ITER_W-1:0];
                if (w_iter_inc >= {1'b0, iter_i}) begin
                    done_d = 1'b1;
                end
            end else begin
                per_d = w_per_inc[ITER_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_q <= '0;
            per_q   <= '0;
            iter_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            delay_q <= delay_d;
            per_q   <= per_d;
            iter_q  <= iter_d;
            done_q  <= done_d;
        end
    end

    assign done_o  = done_q;
    assign first_o = (per_q == '0);

endmodule
`default_nettype wire

// File: rtl/muladd_acc.sv
`default_nettype none
// ============================================================================
// Module      : muladd_acc
// Description : Four-stage multiply-accumulate unit with shift, round, saturate.
// Revision    : 1.0
// ============================================================================
module muladd_acc
    import muladd_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int GUARD_W = 8,
    parameter int ITER_W  = 10,
    parameter int DELAY_W = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               running,
    output logic               done,
    input  logic [DATA_W-1:0]  in0,
    input  logic [DATA_W-1:0]  in1,
    output logic [DATA_W-1:0]  out0,
    input  logic [1:0]         opcode,
    input  logic               sign_en,
    input  logic               sat_en,
    input  logic               round_en,
    input  logic [ITER_W-1:0]  iter,
    input  logic [ITER_W-1:0]  period,
    input  logic [5:0]         shift,
    input  logic [DELAY_W-1:0] delay0
);

    localparam int ACC_W = acc_width(DATA_W, GUARD_W);

    logic [DATA_W-1:0]   a_q, b_q;
    logic [ACC_W-1:0]    p_q, p_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                w_first;
    logic                w_unused;
    logic [2*DATA_W-1:0] w_prod_s, w_prod_u;
    logic [ACC_W-1:0]    w_neg_p, w_rnd, w_r, w_s;

    assign w_unused = running;

    muladd_acc_ctrl #(
        .ITER_W  (ITER_W),
        .DELAY_W (DELAY_W)
    ) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .run_i    (run),
        .iter_i   (iter),
        .period_i (period),
        .delay0_i (delay0),
        .done_o   (done),
        .first_o  (w_first)
    );

    assign w_prod_s = $signed({{DATA_W{a_q[DATA_W-1]}}, a_q}) * $signed({{DATA_W{b_q[DATA_W-1]}}, b_q});
    assign w_prod_u = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
    assign p_d      = sign_en ? {{GUARD_W{w_prod_s[2*DATA_W-1]}}, w_prod_s}
                              : {{GUARD_W{1'b0}}, w_prod_u};
    assign w_neg_p  = '0 - p_q;

    always_comb begin
        acc_d = acc_q;
        case (opcode)
            OP_MACC: acc_d = w_first ? p_q : acc_q + p_q;
            OP_MSUB: acc_d = w_first ? w_neg_p : acc_q - p_q;
            OP_MUL:  acc_d = p_q;
            default: acc_d = w_neg_p;
        endcase
    end

    assign w_rnd = (round_en && shift != 6'd0) ? ({{(ACC_W-1){1'b0}}, 1'b1} << (shift - 6'd1)) : '0;
    assign w_r   = acc_q + w_rnd;

    always_comb begin
        w_s   = '0;
        out_d = w_s[DATA_W-1:0];
        if ({26'd0, shift} >= 32'(ACC_W)) begin
            w_s = (sign_en && w_r[ACC_W-1]) ? '1 : '0;
        end else if (sign_en) begin
            w_s = $signed(w_r) >>> shift;
        end else begin
            w_s = w_r >> shift;
        end

        // Signed overflow: any bit above DATA_W-1 disagrees with the sign.
        if (sat_en && sign_en) begin
            if (w_s[ACC_W-1:DATA_W-1] != {(ACC_W-DATA_W+1){w_s[ACC_W-1]}}) begin
                out_d = w_s[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
            end else begin
                out_d = w_s[DATA_W-1:0];
            end
        end else if (sat_en) begin
            out_d = (|w_s[ACC_W-1:DATA_W]) ? '1 : w_s[DATA_W-1:0];
        end else begin
            out_d = w_s[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            acc_q <= '0;
            out_q <= '0;
        end else begin
            a_q   <= in0;
            b_q   <= in1;
            p_q   <= p_d;
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign out0 = out_q;

endmodule
`default_nettype wire

// File: tb/tb_muladd_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_muladd_acc
// Description : Scoreboard bench for muladd_acc with a reference MAC model.
// Revision    : 1.0
// ============================================================================
module tb_muladd_acc;
    import muladd_pkg::*;

    localparam int DW  = 32;
    localparam int GW  = 8;
    localparam int IW  = 10;
    localparam int DLW = 7;
    localparam int AW  = 2 * DW + GW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           run = 1'b0;
    logic           running = 1'b0;
    logic           done;
    logic [DW-1:0]  in0 = '0, in1 = '0;
    logic [DW-1:0]  out0;
    logic [1:0]     opcode = OP_MACC;
    logic           sign_en = 1'b1, sat_en = 1'b0, round_en = 1'b0;
    logic [IW-1:0]  iter = '0, period = '0;
    logic [5:0]     shift = '0;
    logic [DLW-1:0] delay0 = '0;

    muladd_acc #(.DATA_W(DW), .GUARD_W(GW), .ITER_W(IW), .DELAY_W(DLW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .running(running), .done(done),
        .in0(in0), .in1(in1), .out0(out0), .opcode(opcode), .sign_en(sign_en),
        .sat_en(sat_en), .round_en(round_en), .iter(iter), .period(period),
        .shift(shift), .delay0(delay0)
    );

    always #5 clk = ~clk;

    int gcyc = 0;
    always @(posedge clk) gcyc <= gcyc + 1;

    logic [DW-1:0] obs_out [int];
    logic          obs_done [int];
    always @(negedge clk) begin
        obs_out[gcyc]  = out0;
        obs_done[gcyc] = done;
    end

    typedef struct { int due; logic [DW-1:0] val; } exp_t;
    exp_t          sb[$];
    logic [DW-1:0] opa[$], opb[$];
    int            vectors = 0;
    int            errors = 0;
    int            run_at = 0;

    function automatic logic [DW-1:0] model_out(input logic [AW-1:0] acc, input logic sg,
                                                input logic st, input logic rn, input logic [5:0] sh);
        logic [AW-1:0]        one, r, s;
        logic signed [AW-1:0] ss;
        one = 1;
        r = acc + ((rn && sh != 0) ? (one << (sh - 1)) : '0);
        if (sg) begin
            ss = $signed(r) >>> sh;
            s  = ss;
        end else begin
            s = r >> sh;
        end
        ss = s;
        if (!st) return s[DW-1:0];
        if (sg) begin
            if (ss > 72'sd2147483647) return 32'h7FFF_FFFF;
            if (ss < -72'sd2147483648) return 32'h8000_0000;
            return s[DW-1:0];
        end
        if (s > 72'd4294967295) return 32'hFFFF_FFFF;
        return s[DW-1:0];
    endfunction

    // Issues run, then streams opa/opb starting right after the start delay,
    // pushing the modelled out0 for each product at its due cycle.
    task automatic run_seq(input logic [1:0] op, input logic sg, input logic st, input logic rn,
                           input int it, input int pe, input int sh, input int dl);
        logic [AW-1:0] accm, ea, eb, p;
        logic          first;
        int            n;
        n    = opa.size();
        accm = '0;
        @(posedge clk); #1;
        opcode = op; sign_en = sg; sat_en = st; round_en = rn;
        iter = IW'(it); period = IW'(pe); shift = 6'(sh); delay0 = DLW'(dl);
        run = 1'b1;
        run_at = gcyc;
        @(posedge clk); #1;
        run = 1'b0;
        repeat (dl) begin @(posedge clk); #1; end
        for (int k = 0; k < n; k++) begin
            in0 = opa[k];
            in1 = opb[k];
            ea = sg ? {{(AW-DW){opa[k][DW-1]}}, opa[k]} : {{(AW-DW){1'b0}}, opa[k]};
            eb = sg ? {{(AW-DW){opb[k][DW-1]}}, opb[k]} : {{(AW-DW){1'b0}}, opb[k]};
            p = ea * eb;
            first = ((k % pe) == 0);
            case (op)
                OP_MACC: accm = first ? p : accm + p;
                OP_MSUB: accm = first ? -p : accm - p;
                OP_MUL:  accm = p;
                default: accm = -p;
            endcase
            sb.push_back('{gcyc + OUT_LATENCY, model_out(accm, sg, st, rn, 6'(sh))});
            @(posedge clk); #1;
        end
        in0 = '0;
        in1 = '0;
        repeat (6) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (out0 !== '0) begin errors++; $display("FAIL reset_out0 got %h want 0", out0); end
        vectors++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_macc_signed();
        exp_t e;
        opa.delete(); opb.delete();
        for (int i = 1; i <= 4; i++) begin opa.push_back(DW'(i)); opb.push_back(32'd2); end
        run_seq(OP_MACC, 1'b1, 1'b0, 1'b0, 1, 4, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); vectors++;
            if (!obs_out.exists(e.due) || obs_out[e.due] !== e.val) begin
                errors++; $display("FAIL macc_out cyc %0d got %h want %h", e.due, obs_out[e.due], e.val);
            end
        end
        vectors++;
        if (obs_out[run_at + 8] !== 32'd20) begin errors++; $display("FAIL macc_final got %0d want 20", obs_out[run_at + 8]); end
        vectors++;
        if (obs_done[run_at + 6] !== 1'b0 || obs_done[run_at + 7] !== 1'b1) begin
            errors++; $display("FAIL macc_done got %b%b want 01", obs_done[run_at + 6], obs_done[run_at + 7]);
        end
    endtask

    task automatic test_msub();
        exp_t e;
        opa.delete(); opb.delete();
        repeat (6) begin opa.push_back(32'd3); opb.push_back(-32'sd5); end
        run_seq(OP_MSUB, 1'b1, 1'b0, 1'b0, 3, 2, 0, 3);
        while (sb.size() > 0) begin
            e = sb.pop_front(); vectors++;
            if (!obs_out.exists(e.due) || obs_out[e.due] !== e.val) begin
                errors++; $display("FAIL msub_out cyc %0d got %h want %h", e.due, obs_out[e.due], e.val);
            end
        end
        for (int k = 1; k < 6; k += 2) begin
            vectors++;
            if (obs_out[run_at + 1 + 3 + k + 4] !== 32'd30) begin
                errors++; $display("FAIL msub_period_end k=%0d got %0d want 30", k, obs_out[run_at + 8 + k]);
            end
        end
        vectors++;
        if (obs_done[run_at + 11] !== 1'b0 || obs_done[run_at + 12] !== 1'b1) begin
            errors++; $display("FAIL msub_done got %b%b want 01", obs_done[run_at + 11], obs_done[run_at + 12]);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        for (int st = 1; st >= 0; st--) begin
            opa.delete(); opb.delete();
            repeat (2) begin opa.push_back(32'h7FFF_FFFF); opb.push_back(32'h7FFF_FFFF); end
            run_seq(OP_MACC, 1'b1, 1'(st), 1'b0, 1, 2, 0, 0);
            while (sb.size() > 0) begin
                e = sb.pop_front(); vectors++;
                if (!obs_out.exists(e.due) || obs_out[e.due] !== e.val) begin
                    errors++; $display("FAIL sat_out st=%0d cyc %0d got %h want %h", st, e.due, obs_out[e.due], e.val);
                end
            end
            vectors++;
            if (obs_out[run_at + 6] !== (st == 1 ? 32'h7FFF_FFFF : 32'h0000_0002)) begin
                errors++; $display("FAIL sat_final st=%0d got %h", st, obs_out[run_at + 6]);
            end
        end
    endtask

    task automatic test_rounding();
        logic [DW-1:0] want [3];
        logic [DW-1:0] a    [3];
        logic          rn   [3];
        exp_t e;
        a = '{32'd6, 32'd6, -32'sd6};
        rn = '{1'b1, 1'b0, 1'b1};
        want = '{32'd2, 32'd1, 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            opa.delete(); opb.delete();
            opa.push_back(a[i]); opb.push_back(32'd4);
            run_seq(OP_MUL, 1'b1, 1'b0, rn[i], 1, 1, 4, 0);
            while (sb.size() > 0) begin
                e = sb.pop_front(); vectors++;
                if (!obs_out.exists(e.due) || obs_out[e.due] !== e.val) begin
                    errors++; $display("FAIL round_out case %0d got %h want %h", i, obs_out[e.due], e.val);
                end
            end
            vectors++;
            if (obs_out[run_at + 5] !== want[i]) begin
                errors++; $display("FAIL round_fixed case %0d got %h want %h", i, obs_out[run_at + 5], want[i]);
            end
        end
    endtask

    task automatic test_mneg();
        exp_t e;
        opa.delete(); opb.delete();
        opa = '{32'd5, -32'sd9, 32'd1000};
        opb = '{32'd7, 32'd3, -32'sd1000};
        run_seq(OP_MNEG, 1'b1, 1'b0, 1'b0, 3, 1, 0, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); vectors++;
            if (!obs_out.exists(e.due) || obs_out[e.due] !== e.val) begin
                errors++; $display("FAIL mneg_out cyc %0d got %h want %h", e.due, obs_out[e.due], e.val);
            end
        end
        vectors++;
        if (obs_out[run_at + 6] !== -32'sd35) begin errors++; $display("FAIL mneg_first got %h want ffffffdd", obs_out[run_at + 6]); end
    endtask

    task automatic test_unsigned();
        exp_t e;
        for (int sg = 0; sg < 2; sg++) begin
            opa.delete(); opb.delete();
            opa.push_back(32'hFFFF_FFFF); opb.push_back(32'hFFFF_FFFF);
            run_seq(OP_MUL, 1'(sg), 1'b0, 1'b0, 1, 1, 32, 0);
            while (sb.size() > 0) begin
                e = sb.pop_front(); vectors++;
                if (!obs_out.exists(e.due) || obs_out[e.due] !== e.val) begin
                    errors++; $display("FAIL unsigned_out sg=%0d got %h want %h", sg, obs_out[e.due], e.val);
                end
            end
            vectors++;
            if (obs_out[run_at + 5] !== (sg == 0 ? 32'hFFFF_FFFE : 32'h0)) begin
                errors++; $display("FAIL unsigned_fixed sg=%0d got %h", sg, obs_out[run_at + 5]);
            end
        end
        opa.delete(); opb.delete();
        repeat (2) begin opa.push_back(32'hFFFF_FFFF); opb.push_back(32'hFFFF_FFFF); end
        run_seq(OP_MACC, 1'b0, 1'b1, 1'b0, 1, 2, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); vectors++;
            if (!obs_out.exists(e.due) || obs_out[e.due] !== e.val) begin
                errors++; $display("FAIL usat_out got %h want %h", obs_out[e.due], e.val);
            end
        end
    endtask

    task automatic test_iter_zero();
        opa.delete(); opb.delete();
        run_seq(OP_MACC, 1'b1, 1'b0, 1'b0, 0, 4, 0, 2);
        vectors++;
        if (obs_done[run_at + 1] !== 1'b0 || obs_done[run_at + 2] !== 1'b1) begin
            errors++; $display("FAIL iter0_done got %b%b want 01", obs_done[run_at + 1], obs_done[run_at + 2]);
        end
        vectors++;
        if (obs_done[run_at + 8] !== 1'b1) begin errors++; $display("FAIL iter0_hold got %b want 1", obs_done[run_at + 8]); end
    endtask

    task automatic test_restart();
        exp_t e;
        int   r0;
        @(posedge clk); #1;
        opcode = OP_MACC; iter = 10'd2; period = 10'd4; delay0 = '0; sign_en = 1'b1;
        run = 1'b1;
        r0 = gcyc;
        @(posedge clk); #1;
        run = 1'b0;
        in0 = 32'd9; in1 = 32'd9;
        repeat (4) begin @(posedge clk); #1; end
        opa.delete(); opb.delete();
        for (int i = 1; i <= 3; i++) begin opa.push_back(DW'(i)); opb.push_back(32'd3); end
        run_seq(OP_MACC, 1'b1, 1'b0, 1'b0, 1, 3, 0, 0);
        vectors++;
        if (obs_done[r0 + 1] !== 1'b0) begin errors++; $display("FAIL restart_clear got %b want 0", obs_done[r0 + 1]); end
        while (sb.size() > 0) begin
            e = sb.pop_front(); vectors++;
            if (!obs_out.exists(e.due) || obs_out[e.due] !== e.val) begin
                errors++; $display("FAIL restart_out cyc %0d got %h want %h", e.due, obs_out[e.due], e.val);
            end
        end
        vectors++;
        if (obs_done[run_at + 5] !== 1'b0 || obs_done[run_at + 6] !== 1'b1) begin
            errors++; $display("FAIL restart_done got %b%b want 01", obs_done[run_at + 5], obs_done[run_at + 6]);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        opcode = OP_MUL; iter = '0; period = 10'd1; delay0 = '0; shift = '0;
        sat_en = 1'b0; round_en = 1'b0; sign_en = 1'b1;
        in0 = 32'd7; in1 = 32'd3; run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        vectors++;
        if (out0 !== 32'd21 || done !== 1'b1) begin errors++; $display("FAIL prereset got %h/%b want 15/1", out0, done); end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out0 !== '0 || done !== 1'b0) begin errors++; $display("FAIL async_reset got %h/%b want 0/0", out0, done); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        in0 = '0; in1 = '0;
    endtask

    initial begin
        test_reset();
        test_macc_signed();
        test_msub();
        test_saturation();
        test_rounding();
        test_mneg();
        test_unsigned();
        test_iter_zero();
        test_restart();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muladd_acc.md
Name: muladd_acc

Overview:
- Parametrised multiply-accumulate functional unit; successor to the single-mode 32-bit muladd.
- Adds signed/unsigned operands, guard bits, four opcodes, arithmetic output shift with optional rounding, and saturation to DATA_W.
- Sits in the accelerator datapath as a standard unit: run/running/done control, two data inputs, one data output at fixed latency 4.

Parameters:
- DATA_W, 32, operand and output width.
- GUARD_W, 8, extra accumulator bits above the 2*DATA_W product.
- ITER_W, 10, width of iter/period configuration and counters.
- DELAY_W, 7, width of delay0.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  one-cycle start pulse.
- running  in  1  accelerator running; informational, not used by the datapath.
- done  out  1  high when the programmed iterations are complete.
- in0  in  DATA_W  operand A.
- in1  in  DATA_W  operand B.
- out0  out  DATA_W  shifted, rounded, saturated accumulator; latency 4.
- opcode  in  2  00 MACC, 01 MSUB, 10 MUL, 11 MNEG.
- sign_en  in  1  1: operands are signed; 0: unsigned.
- sat_en  in  1  saturate out0 to the DATA_W range.
- round_en  in  1  round half-up before the shift.
- iter  in  ITER_W  number of periods.
- period  in  ITER_W  products accumulated per period.
- shift  in  6  arithmetic right shift applied to the output.
- delay0  in  DELAY_W  start delay in cycles.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: done=0, out0=0, all pipeline registers, counters and the accumulator are 0.
- Control: run loads delay_cnt=delay0+2 and clears done. While delay_cnt≠0 it decrements, and cur_iter=cur_per=0. If iter==0, done is set during this delay phase.
- Counting (delay_cnt==0, done==0):
  - cur_per increments each cycle.
  - When cur_per+1>=period: cur_per wraps to 0 and cur_iter increments.
  - When cur_iter+1>=iter: done=1.
  - Counting stops while done=1.
- Timing (period=1 behaves as a fresh result every cycle):
  - A run during counting restarts the sequence.
  - done stays 1 until the next run.
- Pipeline:
  - S1: register in0/in1.
  - S2: product P, signed or unsigned per sign_en, 2*DATA_W bits, sign/zero-extended to ACC_W=2*DATA_W+GUARD_W.
  - S3: accumulator.
  - S4: output register.
- Accumulator stage:
  - first = (cur_per==0). This is the control value in the cycle S3 updates; the +2 delay offset aligns the first product of a period with first.
  - first=1: acc=P (MACC/MUL) or −P (MSUB/MNEG).
  - first=0 under MACC: acc+P. Under MSUB: acc−P.
  - MUL and MNEG ignore first: acc=±P every cycle.
  - Wraps modulo 2^ACC_W; no internal saturation.
- Output stage:
  - r = acc + (round_en && shift≠0 ? 1<<(shift−1) : 0).
  - s = r >>> shift; arithmetic when sign_en=1, logical otherwise.
  - shift>=ACC_W gives 0, or −1 for a negative signed value.
  - sat_en=1, signed: clamp to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - sat_en=1, unsigned: clamp to 2^DATA_W−1.
  - sat_en=0: out0 = s[DATA_W−1:0].
- Datapath registers update every cycle regardless of run/done; the consumer samples out0 using the fixed latency.
- Configuration ports must be stable from run until done.

Decomposition:
- Shared package muladd_pkg:
  - opcode localparams OP_MACC, OP_MSUB, OP_MUL, OP_MNEG.
  - OUT_LATENCY=4.
  - function for ACC_W computation.
- One natural sub-module: muladd_acc_ctrl, holding the delay/period/iteration counters and done; it outputs first.
- The datapath and output shift/saturation stay in the top.

Test Plan:
- Signed MACC, DATA_W=32: delay0=0, period=4, iter=1, shift=0, in0=1..4, in1=2 → out0 after the 4th product = 20; done=1 after 4 counting cycles.
- MSUB, period=2, iter=3, in0=3, in1=−5 → each period's final out0 = 30; accumulator reloads at each period start; done after 6 cycles.
- Saturation, signed, sat_en=1, shift=0, period=2: in0=in1=0x7FFFFFFF → out0=0x7FFFFFFF. Same with sat_en=0 → out0 = low 32 bits, 0x00000002.
- Rounding, MUL, shift=4: product 24, round_en=1 → 2; round_en=0 → 1. Product −24, signed, round_en=1 → −1.
- Unsigned, sign_en=0: in0=in1=0xFFFFFFFF, MUL, shift=32 → 0xFFFFFFFE. Same inputs with signed → 0.
- Boundaries:
  - iter=0: done=1 during delay, no counting.
  - run asserted mid-count: counters restart, done cleared.
  - rst_n low mid-accumulation: out0=0, done=0 immediately (asynchronous).
